// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, registered press/release pulses.
// Optional auto-repeat of press while held is built when BUTTON_REPEAT_EN is defined.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5,
  parameter int REPEAT_CYCLES   = 64,
  parameter int RPT_WIDTH       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_raw,
  output logic       button,
  output logic       press,
  // 'release' is a reserved word in SystemVerilog, hence release_pulse
  output logic       release_pulse,
  output logic       checking,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    PRESS_CHECK   = 2'd1,
    PRESSED       = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << CNT_WIDTH) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > (1 << RPT_WIDTH) - 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES out of range for RPT_WIDTH");
  end

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] cnt;

`ifdef BUTTON_REPEAT_EN
  localparam logic [RPT_WIDTH-1:0] RPT_LAST = RPT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [RPT_WIDTH-1:0] RPT_ONE  = RPT_WIDTH'(1);
  logic [RPT_WIDTH-1:0] rpt;
`endif

  assign state_dbg = state;

  // Any opposite-level sample in a CHECK state falls back to the stable state with cnt=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= RELEASED;
      cnt           <= '0;
      button        <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      checking      <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      sync1         <= button_raw;
      sync2         <= sync1;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync2) begin
            state    <= PRESS_CHECK;
            cnt      <= '0;
            checking <= 1'b1;
          end
        end
        PRESS_CHECK: begin
          if (!sync2) begin
            state    <= RELEASED;
            cnt      <= '0;
            checking <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state    <= PRESSED;
            cnt      <= '0;
            button   <= 1'b1;
            press    <= 1'b1;
            checking <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            rpt      <= '0;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state    <= RELEASE_CHECK;
            cnt      <= '0;
            checking <= 1'b1;
`ifdef BUTTON_REPEAT_EN
            rpt      <= '0;
          end else if (rpt == RPT_LAST) begin
            press <= 1'b1;
            rpt   <= '0;
          end else begin
            rpt <= rpt + RPT_ONE;
`endif
          end
        end
        RELEASE_CHECK: begin
          if (sync2) begin
            state    <= PRESSED;
            cnt      <= '0;
            checking <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            rpt      <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            button        <= 1'b0;
            release_pulse <= 1'b1;
            checking      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= RELEASED;
          cnt      <= '0;
          checking <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce at DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64.
// Table of held-input segments, each checked on every edge, plus hand-written repeat/overlap sequences.
module tb_button_debounce;

  localparam logic [1:0] RL = 2'd0;
  localparam logic [1:0] PC = 2'd1;
  localparam logic [1:0] PD = 2'd2;
  localparam logic [1:0] RC = 2'd3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_raw = 1'b0;
  logic       button;
  logic       press;
  logic       release_pulse;
  logic       checking;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  button_debounce #(
    .DEBOUNCE_CYCLES(16),
    .CNT_WIDTH(5),
    .REPEAT_CYCLES(64),
    .RPT_WIDTH(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .button(button),
    .press(press),
    .release_pulse(release_pulse),
    .checking(checking),
    .state_dbg(state_dbg)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic  rst;
    logic  raw;
    int    cycles;
    logic  [5:0] exp;
    string name;
  } vec_t;

  vec_t tbl[$];

  // exp = {button, press, release, checking, state}; checking is high exactly in the CHECK states
  function automatic vec_t mk(logic r, logic raw, int n, logic b, logic p, logic rl,
                              logic [1:0] st, string name);
    vec_t v;
    logic c;
    c = (st == PC) || (st == RC);
    v.rst    = r;
    v.raw    = raw;
    v.cycles = n;
    v.exp    = {b, p, rl, c, st};
    v.name   = name;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs for one edge, then sample 1 time unit after it
  task automatic step(logic r, logic raw);
    rst        = r;
    button_raw = raw;
    @(posedge clk);
    #1;
  endtask

  // press and release must never be high together
  int overlap = 0;
  always @(negedge clk) if (press && release_pulse) overlap++;

  task automatic add_release(string tag);
    tbl.push_back(mk(0, 0, 2,  1, 0, 0, PD, {tag, "_sync"}));
    tbl.push_back(mk(0, 0, 1,  1, 0, 0, RC, {tag, "_enter"}));
    tbl.push_back(mk(0, 0, 15, 1, 0, 0, RC, {tag, "_wait"}));
    tbl.push_back(mk(0, 0, 1,  0, 0, 1, RL, {tag, "_accept"}));
    tbl.push_back(mk(0, 0, 1,  0, 0, 0, RL, {tag, "_drop"}));
  endtask

  logic [7:0] exp_q[$];
  int         press_cnt;
  int         low_cnt;
  logic [7:0] got;

  initial begin
    // reset
    tbl.push_back(mk(1, 0, 2,  0, 0, 0, RL, "reset"));
    // clean press: accepted after edge 19
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "press_sync"));
    tbl.push_back(mk(0, 1, 1,  0, 0, 0, PC, "press_enter"));
    tbl.push_back(mk(0, 1, 15, 0, 0, 0, PC, "press_wait"));
    tbl.push_back(mk(0, 1, 1,  1, 1, 0, PD, "press_accept"));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, PD, "press_drop"));
    // short low during PRESSED bounces back without output change
    tbl.push_back(mk(0, 0, 2,  1, 0, 0, PD, "rbounce_sync"));
    tbl.push_back(mk(0, 0, 3,  1, 0, 0, RC, "rbounce_check"));
    tbl.push_back(mk(0, 1, 2,  1, 0, 0, RC, "rbounce_lag"));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, PD, "rbounce_back"));
    tbl.push_back(mk(0, 1, 10, 1, 0, 0, PD, "rbounce_hold"));
    add_release("rel1");
    // glitch: 10 cycles high then low
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "glitch_sync"));
    tbl.push_back(mk(0, 1, 8,  0, 0, 0, PC, "glitch_check"));
    tbl.push_back(mk(0, 0, 2,  0, 0, 0, PC, "glitch_lag"));
    tbl.push_back(mk(0, 0, 1,  0, 0, 0, RL, "glitch_abort"));
    tbl.push_back(mk(0, 0, 20, 0, 0, 0, RL, "glitch_idle"));
    // bounce train 1,0,1,0 every 3 cycles then held 1
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "bt_a_sync"));
    tbl.push_back(mk(0, 1, 1,  0, 0, 0, PC, "bt_a_enter"));
    tbl.push_back(mk(0, 0, 2,  0, 0, 0, PC, "bt_a_lag"));
    tbl.push_back(mk(0, 0, 1,  0, 0, 0, RL, "bt_a_abort"));
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "bt_b_sync"));
    tbl.push_back(mk(0, 1, 1,  0, 0, 0, PC, "bt_b_enter"));
    tbl.push_back(mk(0, 0, 2,  0, 0, 0, PC, "bt_b_lag"));
    tbl.push_back(mk(0, 0, 1,  0, 0, 0, RL, "bt_b_abort"));
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "bt_final_sync"));
    tbl.push_back(mk(0, 1, 16, 0, 0, 0, PC, "bt_final_wait"));
    tbl.push_back(mk(0, 1, 1,  1, 1, 0, PD, "bt_accept"));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, PD, "bt_drop"));
    add_release("rel2");
    // reset at cycle 8 of PRESS_CHECK, then a full accept again
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "rmid_sync"));
    tbl.push_back(mk(0, 1, 8,  0, 0, 0, PC, "rmid_check"));
    tbl.push_back(mk(1, 1, 1,  0, 0, 0, RL, "rmid_reset"));
    tbl.push_back(mk(0, 1, 2,  0, 0, 0, RL, "rmid_resync"));
    tbl.push_back(mk(0, 1, 1,  0, 0, 0, PC, "rmid_enter"));
    tbl.push_back(mk(0, 1, 15, 0, 0, 0, PC, "rmid_wait"));
    tbl.push_back(mk(0, 1, 1,  1, 1, 0, PD, "rmid_accept"));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, PD, "rmid_drop"));
    add_release("rel3");

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step(tbl[i].rst, tbl[i].raw);
        check(tbl[i].name,
              int'({button, press, release_pulse, checking, state_dbg}),
              int'(tbl[i].exp));
      end
    end

    // long hold: press edges counted from the first raw=1 edge
    exp_q.push_back(8'd19);
`ifdef BUTTON_REPEAT_EN
    exp_q.push_back(8'd83);
    exp_q.push_back(8'd147);
    exp_q.push_back(8'd211);
`endif
    press_cnt = 0;
    low_cnt   = 0;
    for (int e = 1; e <= 219; e++) begin
      step(0, 1);
      if (e >= 19 && !button) low_cnt++;
      if (press) begin
        press_cnt++;
        if (exp_q.size() == 0) begin
          check("hold_extra_press", e, 0);
        end else begin
          got = exp_q.pop_front();
          check("hold_press_edge", e, int'(got));
        end
      end
    end
    check("hold_missing_press", exp_q.size(), 0);
`ifdef BUTTON_REPEAT_EN
    check("hold_press_count", press_cnt, 4);
`else
    check("hold_press_count", press_cnt, 1);
`endif
    check("hold_button_low", low_cnt, 0);

    // release after the hold
    for (int e = 1; e <= 19; e++) begin
      step(0, 0);
      if (e == 18) check("hold_rel_pre", int'({button, release_pulse}), 2);
      if (e == 19) check("hold_rel_accept", int'({button, release_pulse, press}), 2);
    end
    step(0, 0);
    check("hold_rel_drop", int'({button, release_pulse}), 0);

    check("press_release_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions the raw, asynchronous, bouncy push-button for the electronic dice counter.
- Sits directly upstream of the dice: its `button` output drives the dice counter's `button` input, so the dice sees a clean, glitch-free, clock-synchronous level.
- Also produces single-cycle `press` and `release` pulses for downstream logic that counts throws.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a level change. Legal range 1 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 5: width of the debounce counter.
- REPEAT_CYCLES, 64: auto-repeat interval in clocks. Used only with BUTTON_REPEAT_EN.
- RPT_WIDTH, 7: width of the repeat counter. REPEAT_CYCLES must be ≤ 2^RPT_WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- button_raw  input  1  raw push-button, asynchronous to clk, may bounce.
- button  output  1  debounced level; feeds the dice counter's button input.
- press  output  1  one-cycle pulse on an accepted 0→1 transition (and on each repeat if enabled).
- release  output  1  one-cycle pulse on an accepted 1→0 transition.
- checking  output  1  high while in PRESS_CHECK or RELEASE_CHECK.

Behaviour:
- Reset (rst=1 at a clock edge):
  - sync flops, state=RELEASED, debounce counter=0, repeat counter=0.
  - button=0, press=0, release=0, checking=0.
  - Reset overrides every transition, including mid-check.
- Synchronizer: two flops, sync1<=button_raw, sync2<=sync1. The FSM uses only sync2.
- FSM, 4 states:
  - RELEASED: if sync2=1, go to PRESS_CHECK and set cnt=0.
  - PRESS_CHECK:
    - if sync2=0, go to RELEASED and set cnt=0. This is a glitch: no output change.
    - else if cnt=DEBOUNCE_CYCLES-1, go to PRESSED, set button<=1, pulse press.
    - else cnt<=cnt+1.
  - PRESSED: if sync2=0, go to RELEASE_CHECK and set cnt=0.
  - RELEASE_CHECK:
    - if sync2=1, go back to PRESSED and set cnt=0. No output change.
    - else if cnt=DEBOUNCE_CYCLES-1, go to RELEASED, set button<=0, pulse release.
    - else cnt<=cnt+1.
- Press latency: with button_raw sampled high first at edge 1 and held, `button` and `press` go high after edge DEBOUNCE_CYCLES+3. That is edge 19 at the default.
- Release latency: symmetric, DEBOUNCE_CYCLES+3 edges.
- Pulses: press and release are registered and high for exactly one cycle. They are never high together.
- checking is registered: high in the cycle after entering a CHECK state, low once the FSM leaves it.
- Bounce: any opposite-level sample during a CHECK state restarts the accept process from the stable state. No partial credit is kept; cnt always restarts at 0.
- The counter never wraps; it saturates by construction at DEBOUNCE_CYCLES-1.
- `button` changes only on accepted transitions. It is never X after reset.

Optional Feature:
- Macro BUTTON_REPEAT_EN.
- Defined:
  - In PRESSED, rpt counts each cycle.
  - When rpt=REPEAT_CYCLES-1, press pulses for one cycle and rpt resets to 0.
  - rpt clears on entering PRESSED, on leaving PRESSED, and on reset.
  - RELEASE_CHECK freezes rpt at 0; a bounce back to PRESSED restarts the interval.
  - `button` stays high throughout.
- Not defined: no repeat logic and no rpt register. press fires exactly once per accepted press.

Test Plan (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64):
- Clean press: rst 2 cycles, then button_raw=1 held → button=0 through edge 18; button=1 and press=1 after edge 19; press=0 after edge 20; checking=1 during the wait.
- Glitch: button_raw=1 for 10 cycles then 0 → button stays 0, press never pulses, FSM returns to RELEASED, checking drops.
- Bounce train: raw toggles 1,0,1,0 every 3 cycles, then holds 1 → exactly one press pulse, 19 edges after the final 0→1 sample.
- Release: from PRESSED, button_raw=0 held → release=1 and button=0 after edge 19; press stays 0.
- Reset mid-check: rst=1 at cycle 8 of PRESS_CHECK, raw still 1 → all outputs 0 next cycle; after rst drops, a full 19-edge accept is required again.
- Repeat, with BUTTON_REPEAT_EN: hold raw=1 for 200 cycles after acceptance → press pulses at acceptance, then at +64, +128 and +192 cycles; button=1 throughout. Without the macro, only one pulse.
